// File: rtl/dram_reader.sv
// DRAM readback engine: streams a block of 16-bit DRAM words out as bytes,
// high byte first, over a valid/ready byte interface.
module dram_reader #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dump_start,
    input  logic [ADDR_WIDTH-1:0] addr_first,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapture,
        StSendHi,
        StSendLo,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    logic                  mem_read_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [7:0]            byte_out_d;
    logic                  byte_valid_d;
    logic                  busy_d;
    logic                  done_d;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        word_d      = word_q;

        unique case (state_q)
            StIdle: begin
                if (dump_start) begin
                    if (word_count != '0) begin
                        cur_addr_d  = addr_first;
                        remaining_d = word_count;
                        state_d     = StRead;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRead:    state_d = StCapture;
            StCapture: begin
                // Registered DRAM read: data for the READ address is valid now.
                word_d  = mem_data_in;
                state_d = StSendHi;
            end
            StSendHi: begin
                if (byte_ready) state_d = StSendLo;
            end
            StSendLo: begin
                if (byte_ready) begin
                    if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
                        state_d = StDone;
                    end else begin
                        cur_addr_d  = cur_addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        state_d     = StRead;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are precomputed from the next state so they come straight from flops.
    always_comb begin
        mem_read_en_d = (state_d == StRead);
        mem_addr_d    = (state_d == StIdle) ? '0 : cur_addr_d;
        byte_valid_d  = (state_d == StSendHi) || (state_d == StSendLo);
        busy_d        = (state_d != StIdle);
        done_d        = (state_d == StDone);
        byte_out_d    = '0;
        if (state_d == StSendHi) begin
            byte_out_d = word_d[DATA_WIDTH-1 -: 8];
        end else if (state_d == StSendLo) begin
            byte_out_d = word_d[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            mem_read_en <= 1'b0;
            mem_addr    <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            mem_read_en <= mem_read_en_d;
            mem_addr    <= mem_addr_d;
            byte_out    <= byte_out_d;
            byte_valid  <= byte_valid_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_dram_reader.sv
// Scoreboard bench for dram_reader: a DRAM array model answers reads, expected
// addresses/bytes are queued at dump issue and popped by a negedge monitor.
module tb_dram_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dump_start = 1'b0;
    logic [8:0]  addr_first = '0;
    logic [9:0]  word_count = '0;
    logic        mem_read_en;
    logic [8:0]  mem_addr;
    logic [15:0] mem_data_in = '0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        busy;
    logic        done;

    dram_reader #(
        .ADDR_WIDTH(9),
        .DATA_WIDTH(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .dump_start  (dump_start),
        .addr_first  (addr_first),
        .word_count  (word_count),
        .mem_read_en (mem_read_en),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    logic [15:0] dram [512];
    always @(posedge clock) begin
        if (mem_read_en) mem_data_in <= dram[mem_addr];
    end

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_bytes[$];
    logic [8:0] exp_addr[$];
    int pending_done = 0;
    int done_seen = 0;
    int bytes_acc = 0;
    int reads_seen = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h expected=none", name, act);
    endtask

    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ($urandom_range(0, 3) != 0);
            default: byte_ready = 1'b0;
        endcase
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;
    logic       prev_done = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(byte_valid), 32'd1);
                chk("hold_byte", 32'(byte_out), 32'(prev_byte));
            end
            if (mem_read_en) begin
                reads_seen++;
                if (exp_addr.size() == 0) fail_now("unexpected_read", 32'(mem_addr));
                else chk("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
            if (byte_valid) chk("valid_implies_busy", 32'(busy), 32'd1);
            if (byte_valid && byte_ready) begin
                bytes_acc++;
                if (exp_bytes.size() == 0) fail_now("unexpected_byte", 32'(byte_out));
                else chk("byte", 32'(byte_out), 32'(exp_bytes.pop_front()));
            end
            if (done) begin
                chk("done_single", 32'(prev_done), 32'd0);
                if (pending_done == 0) begin
                    fail_now("unexpected_done", 32'(done));
                end else begin
                    pending_done--;
                    chk("done_bytes_left", 32'(exp_bytes.size()), 32'd0);
                end
                done_seen++;
            end
            prev_stall = byte_valid && !byte_ready;
            prev_byte  = byte_out;
            prev_done  = done;
        end
    end

    // Queue the reference outcome, then pulse dump_start; returns #1 after the sampling edge.
    task automatic start_dump(input int addr, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [8:0] a;
            a = 9'((addr + i) % 512);
            exp_addr.push_back(a);
            exp_bytes.push_back(dram[a][15:8]);
            exp_bytes.push_back(dram[a][7:0]);
        end
        pending_done++;
        @(posedge clock);
        #1;
        dump_start = 1'b1;
        addr_first = 9'(addr);
        word_count = 10'(cnt);
        @(posedge clock);
        #1;
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int start;
        int k;
        start = done_seen;
        k = 0;
        while (done_seen == start && k < bound) begin
            @(posedge clock);
            k++;
        end
        if (done_seen == start) fail_now("done_timeout", 32'(k));
        @(posedge clock);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_read_en"}, 32'(mem_read_en), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_byte_out"}, 32'(byte_out), 32'd0);
        chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=%0d expected=finish", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        int t;
        int last;
        int seen;
        int a;
        int c;

        for (int i = 0; i < 512; i++) dram[i] = 16'($urandom);
        dram[5] = 16'hA1B2;
        dram[0] = 16'h0011;
        dram[1] = 16'h2233;
        dram[2] = 16'h4455;
        dram[3] = 16'h6677;

        repeat (3) @(posedge clock);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single word, latency checks
        start_dump(5, 1);
        @(negedge clock);
        chk("t1_read_en", 32'(mem_read_en), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'd5);
        @(negedge clock);
        chk("t1_capture_valid", 32'(byte_valid), 32'd0);
        @(negedge clock);
        chk("t1_hi_valid", 32'(byte_valid), 32'd1);
        chk("t1_hi", 32'(byte_out), 32'hA1);
        @(negedge clock);
        chk("t1_lo", 32'(byte_out), 32'hB2);
        @(negedge clock);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_busy", 32'(busy), 32'd1);
        @(negedge clock);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_done", 32'(done), 32'd0);
        @(posedge clock);
        #1;

        // Four words, read every 4 cycles
        start_dump(0, 4);
        t = 0;
        last = 0;
        seen = 0;
        while (seen < 4 && t < 40) begin
            @(negedge clock);
            t++;
            if (mem_read_en) begin
                if (seen > 0) chk("t2_read_period", 32'(t - last), 32'd4);
                last = t;
                seen++;
            end
        end
        if (seen < 4) fail_now("t2_read_timeout", 32'(seen));
        wait_done(60);

        // Backpressure in SEND_HI
        ready_mode = 2;
        r0 = reads_seen;
        start_dump(5, 1);
        repeat (2) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t3_stall_valid", 32'(byte_valid), 32'd1);
            chk("t3_stall_byte", 32'(byte_out), 32'hA1);
        end
        ready_mode = 0;
        wait_done(40);
        chk("t3_read_count", 32'(reads_seen - r0), 32'd1);

        // Address wrap
        ready_mode = 1;
        start_dump(510, 3);
        wait_done(120);

        // Zero-length dump
        ready_mode = 0;
        r0 = reads_seen;
        start_dump(77, 0);
        @(negedge clock);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_read_en", 32'(mem_read_en), 32'd0);
        chk("t5_valid", 32'(byte_valid), 32'd0);
        @(negedge clock);
        chk("t5_done_drop", 32'(done), 32'd0);
        chk("t5_busy_drop", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        chk("t5_no_read", 32'(reads_seen - r0), 32'd0);

        // Randomized dumps, some with a stray dump_start mid-dump
        for (int n = 0; n < 10; n++) begin
            ready_mode = 1;
            a = int'($urandom_range(0, 511));
            c = int'($urandom_range(0, 7));
            start_dump(a, c);
            if (c > 0 && $urandom_range(0, 1) == 1) begin
                @(posedge clock);
                #1;
                dump_start = 1'b1;
                addr_first = 9'($urandom);
                word_count = 10'($urandom_range(1, 9));
                @(posedge clock);
                #1;
                dump_start = 1'b0;
            end
            wait_done(24 * c + 30);
        end

        // Full 512-word dump
        ready_mode = 0;
        start_dump(300, 512);
        wait_done(24 * 512);

        // Reset during SEND_LO of word 2 of 4
        ready_mode = 0;
        a = int'($urandom_range(0, 511));
        r0 = bytes_acc;
        start_dump(a, 4);
        t = 0;
        while (bytes_acc < r0 + 3 && t < 60) begin
            @(posedge clock);
            t++;
        end
        if (bytes_acc < r0 + 3) fail_now("t6_accept_timeout", 32'(bytes_acc - r0));
        ready_mode = 2;
        @(negedge clock);
        chk("t6_lo_valid", 32'(byte_valid), 32'd1);
        chk("t6_lo_byte", 32'(byte_out), 32'(dram[9'((a + 1) % 512)][7:0]));
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_outputs_zero("t6_abort");
        exp_addr.delete();
        exp_bytes.delete();
        pending_done = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        ready_mode = 1;
        start_dump(123, 2);
        wait_done(80);

        chk("end_bytes_empty", 32'(exp_bytes.size()), 32'd0);
        chk("end_addr_empty", 32'(exp_addr.size()), 32'd0);
        chk("end_pending_done", 32'(pending_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
